// File: rtl/fp_narrow_pack.sv
// fp_narrow_pack: narrows an 8e/23m float to 5e/10m half storage through a
// two-stage valid/ready pipeline (classify+truncate, then round+pack).
module fp_narrow_pack #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);
    localparam logic [2:0] C_NORMAL  = 3'd0;
    localparam logic [2:0] C_SPECIAL = 3'd1;
    localparam logic [2:0] C_OVER    = 3'd2;
    localparam logic [2:0] C_UNDER   = 3'd3;
    localparam logic [2:0] C_ZERO    = 3'd4;

    logic       en1, en2;
    logic       s1_valid, s1_sign, s1_nan, s1_inc, s1_inexact;
    logic [2:0] s1_cls;
    logic [4:0] s1_e5;
    logic [9:0] s1_m10;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    logic [7:0]  e;
    logic [22:0] m;
    logic        guard, sticky, m_nz;
    logic [2:0]  cls_d;
    logic        inc_d, inexact_d;
    logic [4:0]  e5_d;

    always_comb begin
        e         = in_data[30:23];
        m         = in_data[22:0];
        guard     = m[12];
        sticky    = |m[11:0];
        m_nz      = |m;
        cls_d     = e == 8'hFF   ? C_SPECIAL :
                    e == 8'h00   ? C_ZERO    :
                    e <= 8'd112  ? C_UNDER   :
                    e >= 8'd143  ? C_OVER    : C_NORMAL;
        // 112 mod 32 is 16, so the low five bits of e-112 equal e[4:0]-16
        e5_d      = e[4:0] - 5'd16;
        inc_d     = (ROUND_MODE == 0) && guard && (sticky || m[13]);
        inexact_d = cls_d == C_NORMAL ? (guard || sticky) :
                    cls_d == C_ZERO   ? m_nz :
                    (cls_d == C_UNDER || cls_d == C_OVER);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_cls     <= C_NORMAL;
            s1_nan     <= 1'b0;
            s1_e5      <= 5'd0;
            s1_m10     <= 10'd0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
        end else if (en1) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_data[31];
            s1_cls     <= cls_d;
            s1_nan     <= m_nz;
            s1_e5      <= e5_d;
            s1_m10     <= m[22:13];
            s1_inc     <= inc_d;
            s1_inexact <= inexact_d;
        end
    end

    logic        carry, norm_inf;
    logic [9:0]  m_rnd;
    logic [4:0]  e_rnd;
    logic [15:0] data_d;
    logic        ovf_d, unf_d;

    always_comb begin
        {carry, m_rnd} = {1'b0, s1_m10} + {10'd0, s1_inc};
        e_rnd          = s1_e5 + {4'd0, carry};
        norm_inf       = e_rnd == 5'd31;
        data_d         = s1_cls == C_NORMAL  ? (norm_inf ? {s1_sign, 5'h1F, 10'h000} : {s1_sign, e_rnd, m_rnd}) :
                         s1_cls == C_SPECIAL ? {s1_sign, 5'h1F, s1_nan ? 10'h200 : 10'h000} :
                         s1_cls == C_OVER    ? {s1_sign, 5'h1F, 10'h000} : {s1_sign, 15'h0000};
        ovf_d          = (s1_cls == C_NORMAL && norm_inf) || s1_cls == C_OVER;
        unf_d          = s1_cls == C_UNDER;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= data_d;
                out_ovf     <= ovf_d;
                out_unf     <= unf_d;
                out_inexact <= s1_inexact;
            end
        end
    end
endmodule

// File: doc/fp_narrow_pack.md
Name: fp_narrow_pack

Overview:
- Converts the MAC's single-precision-style result (8-bit exponent, bias 127, 23-bit mantissa) back to half-precision storage format (5-bit exponent, bias 15, 10-bit mantissa).
- Reverses the exponent widening done at the multiplier input: rebias by -112, then round, saturate and classify.
- Two-stage valid/ready pipeline between the accumulator output and the result writeback.

Parameters:
ROUND_MODE, 0, 0 = round-to-nearest-even; 1 = truncate toward zero.

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  32  {sign, exp[7:0] bias 127, mant[22:0]}
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  16  {sign, exp[4:0] bias 15, mant[9:0]}
out_ovf  output  1  overflow to infinity, qualified by out_valid
out_unf  output  1  underflow flushed to zero, qualified by out_valid
out_inexact  output  1  discarded nonzero mantissa bits, qualified by out_valid

Behaviour:
- Reset:
  - Asynchronous, active-low; takes effect immediately and discards any in-flight data.
  - s1_valid, out_valid, out_data, out_ovf, out_unf, out_inexact, and all stage registers clear to 0.
  - in_ready reads 1 once reset is released.
- Handshake:
  - en2 = !out_valid | out_ready.
  - en1 = !s1_valid | en2.
  - in_ready = en1 (combinational).
  - A transfer occurs when in_valid & in_ready.
  - Stage 1 loads on en1; s1_valid <= in_valid.
  - Stage 2 loads on en2; out_valid <= s1_valid.
  - Latency: 2 cycles at full throughput, one result per cycle.
  - While stalled (out_valid & !out_ready), out_data and the flags hold stable.
  - Back-pressure fills stage 1 first; in_ready falls only when both stages are full and out_ready = 0.
- Stage 1 (classify and truncate), with e = exp8 and m = mant23:
  - e == 255: class SPECIAL; NaN if m != 0, otherwise infinity.
  - e == 0: class ZERO. Single-precision subnormals flush to zero; inexact = (m != 0); unf = 0.
  - 1 <= e <= 112: class UNDERFLOW; result is signed zero; unf = 1; inexact = 1.
  - e >= 143: class OVERFLOW; result is signed infinity; ovf = 1; inexact = 1.
  - 113 <= e <= 142: class NORMAL.
    - e5 = e - 112, computed as 8-bit subtraction, low 5 bits kept.
    - m10 = m[22:13]; lsb = m[13]; guard = m[12]; sticky = |m[11:0].
    - inc = (ROUND_MODE == 0) & guard & (sticky | lsb).
    - inexact = guard | sticky.
  - Sign always passes through unchanged.
- Stage 2 (round and pack):
  - NORMAL:
    - {carry, m10'} = m10 + inc.
    - If carry, mantissa becomes 0 and e5 increments by 1.
    - If e5 then reaches 31, the output is signed infinity (mantissa 0) with ovf = 1.
  - SPECIAL: exp = 31. Mantissa = 10'h200 for NaN (quiet, sign kept) or 0 for infinity. Flags all 0.
  - OVERFLOW: {s, 5'h1F, 10'h0}.
  - UNDERFLOW and ZERO: {s, 15'h0}.
- Flags are registered together with out_data and change only when en2 is high.
- Simultaneous events: when the output is consumed and a new input is accepted in the same cycle, both stages advance; no bubble and no duplicate.

Test Plan:
- 0x3F800000 in, out_ready = 1 -> out_data 0x3C00 on cycle 2, all flags 0. 0xC0490FDB (-pi) -> 0xC248, inexact = 1.
- 0x3F803000 (tie, lsb = 1) -> 0x3C02, inexact = 1. 0x3F801000 (tie, lsb = 0) -> 0x3C00, inexact = 1. With ROUND_MODE = 1, 0x3F803000 -> 0x3C01.
- 0x477FE000 (65504) -> 0x7BFF, no flags. 0x477FF000 -> rounding carry -> 0x7C00, ovf = 1. 0x48000000 -> 0x7C00, ovf = 1.
- 0x33000000 (2^-25) -> 0x0000, unf = 1. 0x80000001 -> 0x8000, inexact = 1, unf = 0. 0x7FC00000 -> 0x7E00. 0xFF800000 -> 0xFC00, ovf = 0.
- Back-pressure:
  - Stream 5 back-to-back inputs while holding out_ready = 0 for 4 cycles.
  - Expected: in_ready drops after 2 accepts; out_data holds stable.
  - On release, all 5 results emerge in order with no loss or duplication.
- Assert resetn low mid-stream with both stages full -> out_valid = 0 and out_data = 0 immediately; after release, in_ready = 1 and the next input emerges 2 cycles later.
